// File: rtl/dmac_pkg.sv
// Shared DMAC definitions: FIFO depth helper and the flag bundle the
// read/write engines consume for burst-issue decisions.
package dmac_pkg;

  // Entry count from its log2; usable in localparam context.
  function automatic int dmac_depth(input int lg2);
    return 1 << lg2;
  endfunction

  typedef struct packed {
    logic full;
    logic afull;
    logic empty;
    logic aempty;
  } dmac_fifo_flags_t;

endpackage

// File: rtl/dmac_fifo_ctl_if.sv
// Bus bundle between the DMAC read engine (producer), the FIFO and the
// write engine (consumer).
//
// Handshake: wren_i is a write request that is taken at a rising edge only
// when full_o is low and flush_i is low; rden_i is a read request that pops
// rdata_o at a rising edge only when empty_o is low and flush_i is low.
// full_o/empty_o act as the registered ready indications; a request made
// against them is dropped and recorded in the sticky ovf_o/udf_o bits.
interface dmac_fifo_ctl_if #(
  parameter int DEPTH_LG2  = 4,
  parameter int DATA_WIDTH = 32
);
  logic                  flush_i;
  logic                  err_clr_i;
  logic [DEPTH_LG2:0]    afull_lvl_i;
  logic [DEPTH_LG2:0]    aempty_lvl_i;
  logic                  wren_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic                  full_o;
  logic                  afull_o;
  logic                  rden_i;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  empty_o;
  logic                  aempty_o;
  logic [DEPTH_LG2:0]    count_o;
  logic                  ovf_o;
  logic                  udf_o;

  // Engine / controller side.
  modport master (
    output flush_i, err_clr_i, afull_lvl_i, aempty_lvl_i,
    output wren_i, wdata_i, rden_i,
    input  full_o, afull_o, rdata_o, empty_o, aempty_o,
    input  count_o, ovf_o, udf_o
  );

  // FIFO side.
  modport slave (
    input  flush_i, err_clr_i, afull_lvl_i, aempty_lvl_i,
    input  wren_i, wdata_i, rden_i,
    output full_o, afull_o, rdata_o, empty_o, aempty_o,
    output count_o, ovf_o, udf_o
  );
endinterface

// File: rtl/dmac_fifo_ptr.sv
// FIFO pointer: one extra wrap bit above the address bits, advances on
// i_inc, returns to zero on i_clr.
module dmac_fifo_ptr #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_ptr
);
  logic [W-1:0] r_ptr;

  // Pointer register; clear beats increment, natural binary wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_ptr <= '0;
    else if (i_clr) r_ptr <= '0;
    else if (i_inc) r_ptr <= r_ptr + W'(1);
  end

  assign o_ptr = r_ptr;
endmodule

// File: rtl/dmac_fifo_ctl.sv
// First-word-fall-through FIFO with occupancy, programmable almost
// levels, synchronous flush and sticky overflow/underflow flags.
module dmac_fifo_ctl
  import dmac_pkg::*;
#(
  parameter int DEPTH_LG2  = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  dmac_fifo_ctl_if.slave  bus
);
  localparam int DEPTH = dmac_depth(DEPTH_LG2);
  localparam int CW    = DEPTH_LG2 + 1;
  localparam dmac_fifo_flags_t FLAGS_RST = '{full: 1'b0, afull: 1'b0,
                                             empty: 1'b1, aempty: 1'b1};

  logic [CW-1:0]         w_wptr;
  logic [CW-1:0]         w_rptr;
  logic [CW-1:0]         w_count;
  logic [CW-1:0]         w_count_n;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_ovf_n;
  logic                  w_udf_n;
  dmac_fifo_flags_t      w_flags_n;
  dmac_fifo_flags_t      r_flags;
  logic                  r_ovf;
  logic                  r_udf;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Accepts are qualified by the registered flags, so no output ever
  // depends combinationally on wren_i/rden_i.
  assign w_wr_acc = bus.wren_i & ~r_flags.full  & ~bus.flush_i;
  assign w_rd_acc = bus.rden_i & ~r_flags.empty & ~bus.flush_i;

  // Occupancy is the pointer distance; the wrap bit disambiguates full.
  assign w_count = w_wptr - w_rptr;

  dmac_fifo_ptr #(.W(CW)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_wr_acc),
    .i_clr (bus.flush_i),
    .o_ptr (w_wptr)
  );

  dmac_fifo_ptr #(.W(CW)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_rd_acc),
    .i_clr (bus.flush_i),
    .o_ptr (w_rptr)
  );

  // Next occupancy, next flags and next sticky errors (set beats clear).
  always_comb begin
    w_count_n = w_count + CW'(w_wr_acc) - CW'(w_rd_acc);
    w_flags_n = FLAGS_RST;
    if (!bus.flush_i) begin
      w_flags_n.full   = (w_count_n == CW'(DEPTH));
      w_flags_n.afull  = (w_count_n >= bus.afull_lvl_i);
      w_flags_n.empty  = (w_count_n == '0);
      w_flags_n.aempty = (w_count_n <= bus.aempty_lvl_i);
    end
    w_ovf_n = (bus.wren_i & r_flags.full  & ~bus.flush_i) | (r_ovf & ~bus.err_clr_i);
    w_udf_n = (bus.rden_i & r_flags.empty & ~bus.flush_i) | (r_udf & ~bus.err_clr_i);
  end

  // Flag and error registers; flags recompute every edge so level changes
  // show up even without traffic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flags <= FLAGS_RST;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_flags <= w_flags_n;
      r_ovf   <= w_ovf_n;
      r_udf   <= w_udf_n;
    end
  end

  // Storage array, deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[w_wptr[DEPTH_LG2-1:0]] <= bus.wdata_i;
  end

  assign bus.rdata_o  = r_mem[w_rptr[DEPTH_LG2-1:0]];
  assign bus.count_o  = w_count;
  assign bus.full_o   = r_flags.full;
  assign bus.afull_o  = r_flags.afull;
  assign bus.empty_o  = r_flags.empty;
  assign bus.aempty_o = r_flags.aempty;
  assign bus.ovf_o    = r_ovf;
  assign bus.udf_o    = r_udf;
endmodule

// File: tb/tb_dmac_fifo_ctl.sv
// Directed bench for dmac_fifo_ctl (DEPTH_LG2=4, DATA_WIDTH=32).
module tb_dmac_fifo_ctl;
  localparam int LG2 = 4;
  localparam int DW  = 32;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  dmac_fifo_ctl_if #(.DEPTH_LG2(LG2), .DATA_WIDTH(DW)) bus_if ();

  dmac_fifo_ctl #(.DEPTH_LG2(LG2), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Clock: 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_count"},  32'(bus_if.count_o), 32'd0);
    check({tag, "_full"},   32'(bus_if.full_o),  32'd0);
    check({tag, "_afull"},  32'(bus_if.afull_o), 32'd0);
    check({tag, "_empty"},  32'(bus_if.empty_o), 32'd1);
    check({tag, "_aempty"}, 32'(bus_if.aempty_o), 32'd1);
    check({tag, "_ovf"},    32'(bus_if.ovf_o),   32'd0);
    check({tag, "_udf"},    32'(bus_if.udf_o),   32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus_if.flush_i      = 1'b0;
    bus_if.err_clr_i    = 1'b0;
    bus_if.afull_lvl_i  = 5'd16;
    bus_if.aempty_lvl_i = 5'd0;
    bus_if.wren_i       = 1'b0;
    bus_if.wdata_i      = '0;
    bus_if.rden_i       = 1'b0;

    // Reset state.
    step();
    step();
    check_reset_vals("rst");
    rst = 1'b0;

    // Fill 0x1..0x10.
    for (int i = 1; i <= 16; i++) begin
      bus_if.wren_i  = 1'b1;
      bus_if.wdata_i = 32'(i);
      step();
      check("fill_count", 32'(bus_if.count_o), 32'(i));
      if (i == 1) begin
        check("fill_first_empty", 32'(bus_if.empty_o), 32'd0);
        check("fill_first_rdata", bus_if.rdata_o, 32'h1);
      end
      if (i == 15) check("fill_not_full15", 32'(bus_if.full_o), 32'd0);
    end
    check("fill_full", 32'(bus_if.full_o), 32'd1);

    // 17th write is dropped and flagged.
    bus_if.wdata_i = 32'h11;
    step();
    bus_if.wren_i = 1'b0;
    check("ovf_set", 32'(bus_if.ovf_o), 32'd1);
    check("ovf_count", 32'(bus_if.count_o), 32'd16);

    // Drain in order.
    for (int i = 1; i <= 16; i++) begin
      check("drain_data", bus_if.rdata_o, 32'(i));
      bus_if.rden_i = 1'b1;
      step();
      check("drain_count", 32'(bus_if.count_o), 32'(16 - i));
      if (i == 1) check("drain_full_drop", 32'(bus_if.full_o), 32'd0);
    end
    bus_if.rden_i = 1'b0;
    check("drain_empty", 32'(bus_if.empty_o), 32'd1);
    check("drain_no_udf", 32'(bus_if.udf_o), 32'd0);

    // Clear the overflow.
    bus_if.err_clr_i = 1'b1;
    step();
    bus_if.err_clr_i = 1'b0;
    check("ovf_clr", 32'(bus_if.ovf_o), 32'd0);

    // Preload 5, then 40 cycles of simultaneous read+write (pointers wrap).
    for (int k = 0; k < 5; k++) begin
      bus_if.wren_i  = 1'b1;
      bus_if.wdata_i = 32'h100 + 32'(k);
      step();
    end
    check("rw_pre_count", 32'(bus_if.count_o), 32'd5);
    for (int j = 0; j < 40; j++) begin
      check("rw_data", bus_if.rdata_o, 32'h100 + 32'(j));
      bus_if.wren_i  = 1'b1;
      bus_if.wdata_i = 32'h105 + 32'(j);
      bus_if.rden_i  = 1'b1;
      step();
      check("rw_count", 32'(bus_if.count_o), 32'd5);
    end
    bus_if.wren_i = 1'b0;
    check("rw_ovf", 32'(bus_if.ovf_o), 32'd0);
    check("rw_udf", 32'(bus_if.udf_o), 32'd0);
    for (int k = 0; k < 5; k++) begin
      check("rw_tail_data", bus_if.rdata_o, 32'h128 + 32'(k));
      step();
    end
    bus_if.rden_i = 1'b0;
    check("rw_tail_empty", 32'(bus_if.empty_o), 32'd1);

    // Read on empty with simultaneous write of 0xA5.
    bus_if.rden_i  = 1'b1;
    bus_if.wren_i  = 1'b1;
    bus_if.wdata_i = 32'hA5;
    step();
    bus_if.rden_i = 1'b0;
    bus_if.wren_i = 1'b0;
    check("udf_set", 32'(bus_if.udf_o), 32'd1);
    check("udf_count", 32'(bus_if.count_o), 32'd1);
    check("udf_rdata", bus_if.rdata_o, 32'hA5);
    bus_if.err_clr_i = 1'b1;
    step();
    bus_if.err_clr_i = 1'b0;
    check("udf_clr", 32'(bus_if.udf_o), 32'd0);
    bus_if.rden_i = 1'b1;
    step();
    check("udf_pop_empty", 32'(bus_if.empty_o), 32'd1);
    // Underflow coinciding with clear: set wins.
    bus_if.err_clr_i = 1'b1;
    step();
    bus_if.rden_i    = 1'b0;
    bus_if.err_clr_i = 1'b0;
    check("udf_set_wins", 32'(bus_if.udf_o), 32'd1);
    check("udf_set_wins_count", 32'(bus_if.count_o), 32'd0);

    // Almost levels.
    bus_if.afull_lvl_i  = 5'd12;
    bus_if.aempty_lvl_i = 5'd3;
    step();
    check("lvl_idle_afull", 32'(bus_if.afull_o), 32'd0);
    check("lvl_idle_aempty", 32'(bus_if.aempty_o), 32'd1);
    for (int k = 1; k <= 12; k++) begin
      bus_if.wren_i  = 1'b1;
      bus_if.wdata_i = 32'h200 + 32'(k);
      step();
      check("lvl_afull",  32'(bus_if.afull_o),  (k >= 12) ? 32'd1 : 32'd0);
      check("lvl_aempty", 32'(bus_if.aempty_o), (k <= 3)  ? 32'd1 : 32'd0);
    end
    bus_if.wren_i      = 1'b0;
    bus_if.afull_lvl_i = 5'd13;
    step();
    check("lvl_change_afull", 32'(bus_if.afull_o), 32'd0);
    check("lvl_change_count", 32'(bus_if.count_o), 32'd12);

    // Bring count to 9, then flush with both requests high.
    bus_if.rden_i = 1'b1;
    step();
    step();
    step();
    bus_if.rden_i = 1'b0;
    check("pre_flush_count", 32'(bus_if.count_o), 32'd9);
    check("pre_flush_data", bus_if.rdata_o, 32'h204);
    bus_if.flush_i = 1'b1;
    bus_if.wren_i  = 1'b1;
    bus_if.rden_i  = 1'b1;
    bus_if.wdata_i = 32'hDEAD;
    step();
    bus_if.flush_i = 1'b0;
    bus_if.wren_i  = 1'b0;
    bus_if.rden_i  = 1'b0;
    check("flush_count", 32'(bus_if.count_o), 32'd0);
    check("flush_empty", 32'(bus_if.empty_o), 32'd1);
    check("flush_aempty", 32'(bus_if.aempty_o), 32'd1);
    check("flush_afull", 32'(bus_if.afull_o), 32'd0);
    check("flush_udf_kept", 32'(bus_if.udf_o), 32'd1);
    check("flush_ovf_kept", 32'(bus_if.ovf_o), 32'd0);
    bus_if.err_clr_i = 1'b1;
    step();
    bus_if.err_clr_i = 1'b0;
    check("post_flush_udf_clr", 32'(bus_if.udf_o), 32'd0);

    // Async reset mid-burst at count 7.
    bus_if.afull_lvl_i  = 5'd4;
    bus_if.aempty_lvl_i = 5'd2;
    for (int k = 0; k < 7; k++) begin
      bus_if.wren_i  = 1'b1;
      bus_if.wdata_i = 32'h300 + 32'(k);
      step();
    end
    check("burst_count", 32'(bus_if.count_o), 32'd7);
    check("burst_afull", 32'(bus_if.afull_o), 32'd1);
    bus_if.wdata_i = 32'h307;
    #3;
    rst = 1'b1;
    #1;
    check_reset_vals("arst");
    bus_if.wren_i = 1'b0;
    step();
    rst = 1'b0;
    bus_if.wren_i  = 1'b1;
    bus_if.wdata_i = 32'h77;
    step();
    bus_if.wren_i = 1'b0;
    check("post_rst_empty", 32'(bus_if.empty_o), 32'd0);
    check("post_rst_count", 32'(bus_if.count_o), 32'd1);
    check("post_rst_rdata", bus_if.rdata_o, 32'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmac_fifo_ctl.md
# dmac_fifo_ctl

Parametrised first-word-fall-through FIFO for the DMAC datapath, the successor to the basic DMAC FIFO. On top of full/empty it adds an occupancy count, programmable almost-full/almost-empty levels, a synchronous flush, and sticky overflow/underflow error flags. Illegal accesses are dropped and flagged instead of halting simulation. It sits between the DMAC read engine (producer) and write engine (consumer), and its flags feed burst-issue decisions.

## Interface
- DEPTH_LG2, 4, log2 of entry count; DEPTH = 2^DEPTH_LG2; legal range 1..10
- DATA_WIDTH, 32, entry width in bits
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- flush_i  in  1  synchronous flush; empties the FIFO
- err_clr_i  in  1  clears sticky error flags
- afull_lvl_i  in  DEPTH_LG2+1  almost-full level; quasi-static
- aempty_lvl_i  in  DEPTH_LG2+1  almost-empty level; quasi-static
- wren_i  in  1  write request
- wdata_i  in  DATA_WIDTH  write data
- full_o  out  1  count == DEPTH
- afull_o  out  1  count >= afull_lvl_i
- rden_i  in  1  read request; pops the head entry
- rdata_o  out  DATA_WIDTH  head entry (fall-through)
- empty_o  out  1  count == 0
- aempty_o  out  1  count <= aempty_lvl_i
- count_o  out  DEPTH_LG2+1  occupancy, 0..DEPTH
- ovf_o  out  1  sticky: write attempted while full
- udf_o  out  1  sticky: read attempted while empty

## Operation
- Accepted write: wr_acc = wren_i & ~full_o & ~flush_i. Accepted read: rd_acc = rden_i & ~empty_o & ~flush_i. Flags are the registered values.
- Pointers are DEPTH_LG2+1 bits and wrap naturally. Memory is indexed by the low DEPTH_LG2 bits.
- count_n = count + wr_acc − rd_acc. With both accepted, count is unchanged.
- When full, a simultaneous read and write gives: read accepted, write rejected, ovf set. There is no write-through-when-full.
- When empty, a simultaneous read and write gives: write accepted, read rejected, udf set. There is no read-through-when-empty.
- Flush: pointers and count go to 0 and flags take their reset values. Any rden_i/wren_i in the same cycle is ignored and does not set ovf/udf. Sticky errors are kept through a flush.
- ovf_o sets on wren_i & full_o & ~flush_i. udf_o sets on rden_i & empty_o & ~flush_i. Both clear on err_clr_i. If set and clear occur in the same cycle, set wins.
- All flags (full, empty, afull, aempty) are registered and computed from count_n, using the current-cycle values of the level inputs.
- A level input change is reflected one edge later, even without traffic.
- afull_lvl_i = 0 forces afull_o to 1 from the first post-reset edge. aempty_lvl_i >= DEPTH forces aempty_o to 1.
- Memory is not reset. rdata_o is don't-care while empty_o = 1.

## Timing
- Reset values: full_o 0, afull_o 0, empty_o 1, aempty_o 1, count_o 0, ovf_o 0, udf_o 0, pointers 0. These take effect asynchronously on rst assertion, including mid-transfer.
- Write-to-read latency is 1 cycle. After a write accepted at edge k, empty_o = 0 and rdata_o = wdata after edge k.
- Read pops at the edge. The next entry appears on rdata_o combinationally after that edge.
- full_o asserts at the edge that accepts the DEPTH-th write. It deasserts at the edge after the first accepted read.
- count_o, flags, and error bits all change only on clock edges. No output has a combinational path from wren_i or rden_i.

## Structure
- Shared package dmac_pkg holds:
  - a localparam function for DEPTH from DEPTH_LG2;
  - a typedef struct packed {full, afull, empty, aempty} dmac_fifo_flags_t, reused by the engines.
- One sub-module, dmac_fifo_ptr: pointer register, increment, and wrap. It is instantiated twice (write side, read side) with an inc and clear input.
- Storage is an inferred register array. A simple-dual-port RAM swap must not change the port timing.

## Test plan
- Reset then fill: assert rst, release, write 0x1..0x10 (DEPTH_LG2=4) → count_o steps to 16, full_o = 1 after the 16th edge; a 17th write sets ovf_o = 1 and count stays 16; reading 16 times returns 0x1..0x10 in order, then empty_o = 1.
- Simultaneous read and write at count 5 for 40 cycles → count_o stays 5 throughout, pointers wrap past 31→0, data stays in order, no error flags.
- Read on empty with a simultaneous write of 0xA5 → udf_o = 1, count_o = 1, rdata_o = 0xA5 next cycle; err_clr_i pulse → udf_o = 0 next edge. A udf event coinciding with err_clr_i leaves udf_o = 1.
- Levels: afull_lvl=12, aempty_lvl=3. Write 12 entries → afull_o rises at the 12th edge and aempty_o falls at the 4th. Change afull_lvl to 13 → afull_o falls one edge later.
- Flush at count 9 with wren_i=rden_i=1 in the same cycle → next edge count_o = 0, empty_o = 1, aempty_o = 1, ovf/udf unchanged.
- Async reset mid-burst: assert rst between edges at count 7 → all outputs reach reset values before the next edge. After release, the first write becomes visible after 1 edge.
